stack_ctrl: RTL

Sequencer for the data-stack RAM in the stack-machine datapath. It takes push, pop and clear requests from the instruction FSM over a req/ack handshake and drives the stack RAM port. It maintains the top-of-stack pointer and full/empty status, and records overflow and underflow in sticky error flags. Replaces the ad-hoc stack pointer arithmetic in the control FSM with a single owner of the stack resource.

---
 rtl/stack_ctrl_if.sv | 26 ++
 rtl/stack_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_if.sv
// Request/response handshake between the instruction FSM and the stack sequencer.
interface stack_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  push_req;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  pop_req;
   logic                  clear_req;
   logic                  push_ack;
   logic                  pop_ack;
   logic                  clear_ack;
   logic [DATA_WIDTH-1:0] pop_data;
   logic                  ready;

   // Requester side (instruction FSM).
   modport master (
      output push_req, push_data, pop_req, clear_req,
      input  push_ack, pop_ack, clear_ack, pop_data, ready
   );

   // Stack sequencer side.
   modport slave (
      input  push_req, push_data, pop_req, clear_req,
      output push_ack, pop_ack, clear_ack, pop_data, ready
   );
endinterface

// File: rtl/stack_ctrl.sv
// Single owner of the data-stack RAM: serialises push/pop/clear requests,
// tracks the top-of-stack pointer and keeps sticky overflow/underflow flags.
// All RAM controls and acks are registered, so they are computed on the
// transition into the state in which they must be visible.
module stack_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   stack_ctrl_if.slave           bus,
   output logic [ADDR_WIDTH:0]   tos_pointer,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow_err,
   output logic                  underflow_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_we,
   output logic                  ram_re,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int PW = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH    = 3'd1,
      POP_RD  = 3'd2,
      POP_CAP = 3'd3,
      POP_ACK = 3'd4,
      CLEAR   = 3'd5,
      ERR     = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         tos_q, tos_d;
   logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
   logic                  push_ack_q, push_ack_d;
   logic                  pop_ack_q, pop_ack_d;
   logic                  clear_ack_q, clear_ack_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_re_q, ram_re_d;

   logic                  is_full, is_empty;
   logic [PW-1:0]         tos_m1;

   assign is_full  = (tos_q == PW'(DEPTH));
   assign is_empty = (tos_q == '0);
   assign tos_m1   = tos_q - PW'(1);

   // Next-state and next-output decode; acks and RAM strobes default low so
   // they pulse for exactly one cycle.
   always_comb begin
      state_d     = state_q;
      tos_d       = tos_q;
      pop_data_d  = pop_data_q;
      push_ack_d  = 1'b0;
      pop_ack_d   = 1'b0;
      clear_ack_d = 1'b0;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      ram_re_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.clear_req) begin
               state_d     = CLEAR;
               clear_ack_d = 1'b1;
            end else if (bus.pop_req) begin
               if (is_empty) begin
                  state_d   = ERR;
                  unf_d     = 1'b1;
                  pop_ack_d = 1'b1;
               end else begin
                  state_d    = POP_RD;
                  ram_re_d   = 1'b1;
                  ram_addr_d = tos_m1[ADDR_WIDTH-1:0];
               end
            end else if (bus.push_req) begin
               if (is_full) begin
                  state_d    = ERR;
                  ovf_d      = 1'b1;
                  push_ack_d = 1'b1;
               end else begin
                  state_d     = PUSH;
                  ram_we_d    = 1'b1;
                  ram_addr_d  = tos_q[ADDR_WIDTH-1:0];
                  ram_wdata_d = bus.push_data;
                  push_ack_d  = 1'b1;
               end
            end
         end
         PUSH: begin
            tos_d   = tos_q + PW'(1);
            state_d = IDLE;
         end
         POP_RD: begin
            tos_d   = tos_m1;
            state_d = POP_CAP;
         end
         POP_CAP: begin
            // RAM data is valid the cycle after the read strobe.
            pop_data_d = ram_rdata;
            pop_ack_d  = 1'b1;
            state_d    = POP_ACK;
         end
         POP_ACK: state_d = IDLE;
         CLEAR: begin
            tos_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = IDLE;
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; synchronous active-low reset aborts any op.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         tos_q       <= '0;
         pop_data_q  <= '0;
         push_ack_q  <= 1'b0;
         pop_ack_q   <= 1'b0;
         clear_ack_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
         ram_re_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tos_q       <= tos_d;
         pop_data_q  <= pop_data_d;
         push_ack_q  <= push_ack_d;
         pop_ack_q   <= pop_ack_d;
         clear_ack_q <= clear_ack_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
         ram_re_q    <= ram_re_d;
      end
   end

   assign bus.push_ack  = push_ack_q;
   assign bus.pop_ack   = pop_ack_q;
   assign bus.clear_ack = clear_ack_q;
   assign bus.pop_data  = pop_data_q;
   assign bus.ready     = (state_q == IDLE);

   assign tos_pointer   = tos_q;
   assign full          = is_full;
   assign empty         = is_empty;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign ram_we        = ram_we_q;
   assign ram_re        = ram_re_q;

endmodule
